// File: rtl/uart_periph.sv
// rtl/uart_periph.sv - memory-mapped 8N1 UART peripheral with CTRL/STAT/BAUD/TDR/RDR registers
//
// Purpose:
//   Register block plus 8N1 transmitter and receiver sitting behind the IO
//   address decoder. Bit timing comes from BAUD (clocks per bit).
//
// Parameters:
//   DEFAULT_BAUD   BAUD reset value, clocks per bit
//   RX_FIFO_DEPTH  RX FIFO entries, power of 2 (only with UART_RX_FIFO_EN)
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   we       in   1   register write strobe
//   rd_en    in   1   register read strobe (RDR read side effect)
//   reg_sel  in   3   CTRL=0 STAT=1 BAUD=2 TDR=3 RDR=4
//   wdata    in   32  write data
//   rdata    out  32  read data, combinational from reg_sel
//   rx       in   1   serial input, asynchronous
//   tx       out  1   serial output, idle high
//   irq      out  1   CTRL.RXNEIE & STAT.RXNE
//
// Configuration macro:
//   UART_RX_FIFO_EN  when defined the RX store is an RX_FIFO_DEPTH-entry FIFO
//                    and STAT[7:5] report its occupancy; otherwise a single RDR.

module uart_periph #(
    parameter logic [15:0] DEFAULT_BAUD  = 16'd434,
    parameter int          RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        rd_en,
    input  logic [2:0]  reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_STAT = 3'd1;
    localparam logic [2:0] REG_BAUD = 3'd2;
    localparam logic [2:0] REG_TDR  = 3'd3;
    localparam logic [2:0] REG_RDR  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [2:0]  ctrl;
    logic [15:0] baud;
    logic [15:0] baud_eff;
    logic [7:0]  tdr;
    logic        txe;
    logic        tc;
    logic        ore;
    logic        fe;
    logic        rxne;
    logic [7:0]  rdr_view;
    logic [2:0]  occ;
    logic        txen;
    logic        rxen;
    logic        rxneie;
    logic        stat_wr;
    logic        tdr_wr;
    logic        rdr_read;
    logic        rx_overrun;
    logic        unused;

    assign txen     = ctrl[0];
    assign rxen     = ctrl[1];
    assign rxneie   = ctrl[2];
    assign stat_wr  = we && (reg_sel == REG_STAT);
    assign rdr_read = rd_en && (reg_sel == REG_RDR);
    assign irq      = rxneie && rxne;

    // BAUD values below 2 would leave no room for the half-bit RX sample.
    assign baud_eff = (baud < 16'd2) ? 16'd2 : baud;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= 3'd0;
            baud <= DEFAULT_BAUD;
        end else if (we) begin
            if (reg_sel == REG_CTRL) ctrl <= wdata[2:0];
            if (reg_sel == REG_BAUD) baud <= wdata[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t tx_state;
    uart_state_t tx_next;
    logic [15:0] tx_cnt;
    logic [15:0] tx_len;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_bit_done;
    logic        tx_load;
    logic        tx_frame_end;

    assign tx_bit_done = (tx_cnt == tx_len - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= S_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (txen && !txe) tx_next = S_START;
            S_START: if (tx_bit_done) tx_next = S_DATA;
            S_DATA:  if (tx_bit_done && (tx_bit == 3'd7)) tx_next = S_STOP;
            S_STOP:  if (tx_bit_done) tx_next = (txen && !txe) ? S_START : S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_load      = 1'b0;
        tx_frame_end = 1'b0;
        tx           = 1'b1;
        case (tx_state)
            S_IDLE:  tx_load = txen && !txe;
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_shift[0];
            S_STOP: begin
                tx_load      = tx_bit_done && txen && !txe;
                tx_frame_end = tx_bit_done && !tx_load;
            end
            default: tx = 1'b1;
        endcase
    end

    // Bit length is re-latched at every bit boundary so a BAUD write never
    // stretches or truncates the bit in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt   <= 16'd0;
            tx_len   <= 16'd2;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
        end else if (tx_load) begin
            tx_shift <= tdr;
            tx_cnt   <= 16'd0;
            tx_len   <= baud_eff;
            tx_bit   <= 3'd0;
        end else if (tx_state != S_IDLE) begin
            if (tx_bit_done) begin
                tx_cnt <= 16'd0;
                tx_len <= baud_eff;
                if (tx_state == S_DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // A TDR write landing in the same cycle the holding register drains into
    // the shifter is accepted: the shifter takes the old byte, TDR the new one.
    assign tdr_wr = we && (reg_sel == REG_TDR) && (txe || tx_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdr <= 8'd0;
            txe <= 1'b1;
            tc  <= 1'b1;
        end else begin
            if (tx_load) txe <= 1'b1;
            if (tdr_wr) begin
                tdr <= wdata[7:0];
                txe <= 1'b0;
                tc  <= 1'b0;
            end else if (tx_frame_end) begin
                tc <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    uart_state_t rx_state;
    uart_state_t rx_next;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        rx_fall;
    logic [15:0] rx_cnt;
    logic [15:0] rx_len;
    logic [15:0] rx_target;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_tick;
    logic        rx_deliver;
    logic        rx_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev && !rx_sync;

    // START samples at the half-bit point; every later sample is one full
    // bit after the previous one, so data bits are sampled mid-bit.
    assign rx_target = (rx_state == S_START) ? ((rx_len >> 1) - 16'd1) : (rx_len - 16'd1);
    assign rx_tick   = (rx_cnt == rx_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= S_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        if (!rxen) begin
            rx_next = S_IDLE;
        end else begin
            case (rx_state)
                S_IDLE:  if (rx_fall) rx_next = S_START;
                S_START: if (rx_tick) rx_next = rx_sync ? S_IDLE : S_DATA;
                S_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = S_STOP;
                S_STOP:  if (rx_tick) rx_next = S_IDLE;
                default: rx_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_deliver   = 1'b0;
        rx_frame_err = 1'b0;
        if (rxen && (rx_state == S_STOP) && rx_tick) begin
            rx_deliver   = rx_sync;
            rx_frame_err = !rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= 16'd0;
            rx_len   <= 16'd2;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else if ((rx_state == S_IDLE) || !rxen) begin
            rx_cnt <= 16'd0;
            rx_len <= baud_eff;
            rx_bit <= 3'd0;
        end else if (rx_tick) begin
            rx_cnt <= 16'd0;
            rx_len <= baud_eff;
            if (rx_state == S_DATA) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt + 16'd1;
        end
    end

    // Error flags: hardware set wins over a software clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ore <= 1'b0;
            fe  <= 1'b0;
        end else begin
            if (stat_wr && wdata[3]) ore <= 1'b0;
            if (stat_wr && wdata[4]) fe  <= 1'b0;
            if (rx_overrun)          ore <= 1'b1;
            if (rx_frame_err)        fe  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX store
    // ------------------------------------------------------------------
`ifdef UART_RX_FIFO_EN
    localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam logic [AW:0] FIFO_FULL = (AW + 1)'(RX_FIFO_DEPTH);

    logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;

    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign fifo_pop   = rdr_read && rxne;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_push  = rx_deliver && (!fifo_full || fifo_pop);
    assign rx_overrun = rx_deliver && fifo_full && !fifo_pop;
    assign rxne       = (fifo_cnt != '0);
    assign rdr_view   = rxne ? fifo_mem[rd_ptr] : 8'h00;
    assign occ        = (int'(fifo_cnt) > 7) ? 3'd7 : 3'(fifo_cnt);
    assign unused     = ^{wdata[31:16]};

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
`else
    logic [7:0] rdr;

    assign rdr_view   = rdr;
    assign occ        = 3'd0;
    assign rx_overrun = rx_deliver && rxne && !rdr_read;
    assign unused     = ^{wdata[31:16], (RX_FIFO_DEPTH != 0)};

    // A read in the same cycle as a delivery returns the old byte while the
    // new one is loaded, so RXNE stays set and no overrun is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdr  <= 8'd0;
            rxne <= 1'b0;
        end else if (rx_deliver && (!rxne || rdr_read)) begin
            rdr  <= rx_shift;
            rxne <= 1'b1;
        end else if (rdr_read) begin
            rxne <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            REG_CTRL: rdata = {29'd0, ctrl};
            REG_STAT: rdata = {24'd0, occ, fe, ore, rxne, tc, txe};
            REG_BAUD: rdata = {16'd0, baud};
            REG_TDR:  rdata = {24'd0, tdr};
            REG_RDR:  rdata = {24'd0, rdr_view};
            default:  rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_periph.sv
// tb/tb_uart_periph.sv - self-checking bench for uart_periph

module tb_uart_periph;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic        rd_en;
    logic [2:0]  reg_sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rx;
    logic        tx;
    logic        irq;

    always #5 clk = ~clk;

    uart_periph dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .rd_en   (rd_en),
        .reg_sel (reg_sel),
        .wdata   (wdata),
        .rdata   (rdata),
        .rx      (rx),
        .tx      (tx),
        .irq     (irq)
    );

`ifdef UART_RX_FIFO_EN
    localparam int          NB_OVR   = 5;
    localparam logic [31:0] STAT_OVR = 32'h8F;
`else
    localparam int          NB_OVR   = 2;
    localparam logic [31:0] STAT_OVR = 32'h0F;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        do_wr;
        logic [2:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [11];

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    int         tx_starts [$];
    int         tx_bclk = 4;
    bit         mon_en  = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; reg_sel = sel; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] sel, output logic [31:0] d);
        @(negedge clk);
        reg_sel = sel; rd_en = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_stat(input logic [31:0] mask, input logic [31:0] val,
                             input int budget, input string name);
        int n = 0;
        reg_sel = 3'd1; rd_en = 1'b0;
        #1;
        while (((rdata & mask) !== val) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check(name, rdata & mask, val);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int bclk);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = fr[i];
            repeat (bclk - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    // TX line monitor: decodes frames mid-bit and checks them against tx_q.
    initial begin
        logic       prev;
        logic [7:0] b;
        int         n0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en && prev && !tx) begin
                n0 = cyc;
                repeat (tx_bclk / 2) @(negedge clk);
                check("tx_start_bit", {31'd0, tx}, 32'd0);
                for (int k = 0; k < 8; k++) begin
                    repeat (tx_bclk) @(negedge clk);
                    b[k] = tx;
                end
                repeat (tx_bclk) @(negedge clk);
                check("tx_stop_bit", {31'd0, tx}, 32'd1);
                check("tx_frame_expected", {31'd0, (tx_q.size() != 0)}, 32'd1);
                if (tx_q.size() != 0) check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
                tx_starts.push_back(n0);
            end
            prev = tx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [9:0]  fr;
        int          n;

        vt[0]  = '{1'b0, 3'd1, 32'h0,        32'h03};
        vt[1]  = '{1'b0, 3'd2, 32'h0,        32'd434};
        vt[2]  = '{1'b0, 3'd0, 32'h0,        32'h00};
        vt[3]  = '{1'b0, 3'd4, 32'h0,        32'h00};
        vt[4]  = '{1'b0, 3'd3, 32'h0,        32'h00};
        vt[5]  = '{1'b1, 3'd0, 32'hFF,       32'h07};
        vt[6]  = '{1'b1, 3'd0, 32'h0,        32'h00};
        vt[7]  = '{1'b1, 3'd2, 32'h0001_2345, 32'h2345};
        vt[8]  = '{1'b1, 3'd5, 32'hFFFF,     32'h00};
        vt[9]  = '{1'b0, 3'd7, 32'h0,        32'h00};
        vt[10] = '{1'b1, 3'd1, 32'hFF,       32'h03};

        rst_n = 1'b0; we = 1'b0; rd_en = 1'b0; rx = 1'b1; reg_sel = 3'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Register table
        for (int i = 0; i < 11; i++) begin
            if (vt[i].do_wr) wr(vt[i].sel, vt[i].wd);
            rd(vt[i].sel, d);
            check($sformatf("reg_vec%0d", i), d, vt[i].exp);
        end

        // Single 0xA5 frame at BAUD=4, checked cycle by cycle
        wr(3'd2, 32'd4);
        wr(3'd0, 32'd1);
        tx_bclk = 4;
        tx_q.push_back(8'hA5);
        wr(3'd3, 32'hA5);
        reg_sel = 3'd1;
        n = 0;
        while ((tx !== 1'b0) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check("a5_start_seen", {31'd0, tx}, 32'd0);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            check($sformatf("a5_cycle%0d", i), {31'd0, tx}, {31'd0, fr[i / 4]});
            if (i == 20) check("a5_stat_midframe", rdata, 32'h01);
            @(negedge clk);
        end
        check("a5_stat_tc", rdata, 32'h03);
        repeat (4) @(negedge clk);

        // Back-to-back: two accepted writes, third dropped while TXE=0
        tx_starts.delete();
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        @(negedge clk); we = 1'b1; reg_sel = 3'd3; wdata = 32'h11;
        @(negedge clk); wdata = 32'h22;
        @(negedge clk); wdata = 32'h33;
        @(negedge clk); we = 1'b0;
        rd(3'd3, d);
        check("b2b_tdr_holds_second", d, 32'h22);
        wait_stat(32'h02, 32'h02, 200, "b2b_tc");
        repeat (4) @(negedge clk);
        check("b2b_frames", tx_starts.size(), 32'd2);
        if (tx_starts.size() >= 2) check("b2b_no_gap", tx_starts[1] - tx_starts[0], 32'd40);
        check("tx_queue_drained", tx_q.size(), 32'd0);

        // BAUD=1 behaves as 2 clocks per bit
        wr(3'd2, 32'd1);
        tx_bclk = 2;
        tx_q.push_back(8'h5A);
        wr(3'd3, 32'h5A);
        wait_stat(32'h02, 32'h02, 100, "baud1_tc");
        repeat (4) @(negedge clk);
        check("baud1_queue_drained", tx_q.size(), 32'd0);
        rd(3'd2, d);
        check("baud1_readback", d, 32'd1);

        // RX single byte with interrupt
        wr(3'd2, 32'd8);
        wr(3'd0, 32'd6);
        rx_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, 8);
        wait_stat(32'h04, 32'h04, 50, "rx1_rxne");
        check("rx1_irq", {31'd0, irq}, 32'd1);
        rd(3'd1, d);
        check("rx1_stat", d, 32'h07);
        rd(3'd4, d);
        check("rx1_rdr", d, {24'd0, rx_q.pop_front()});
        check("rx1_irq_clear", {31'd0, irq}, 32'd0);
        rd(3'd1, d);
        check("rx1_stat_clear", d, 32'h03);

        // Overrun: one more byte than the store holds
        for (int i = 0; i < NB_OVR; i++) begin
            if (i < NB_OVR - 1) rx_q.push_back(8'h41 + 8'(i * 17));
            send_byte(8'h41 + 8'(i * 17), 1'b1, 8);
        end
        repeat (8) @(negedge clk);
        rd(3'd1, d);
        check("ovr_stat", d, STAT_OVR);
        for (int i = 0; i < NB_OVR - 1; i++) begin
            rd(3'd4, d);
            check($sformatf("ovr_rdr%0d", i), d, {24'd0, rx_q.pop_front()});
        end
        wr(3'd1, 32'h08);
        rd(3'd1, d);
        check("ovr_cleared", d, 32'h03);

        // Framing error: stop bit low
        send_byte(8'h77, 1'b0, 8);
        repeat (8) @(negedge clk);
        rd(3'd1, d);
        check("fe_stat", d, 32'h13);
        wr(3'd1, 32'h10);
        rd(3'd1, d);
        check("fe_cleared", d, 32'h03);

        // RXEN off: line activity is ignored
        wr(3'd0, 32'd0);
        send_byte(8'h81, 1'b1, 8);
        repeat (8) @(negedge clk);
        rd(3'd1, d);
        check("rxen_off_stat", d, 32'h03);

        // Reset in the middle of a TX frame
        mon_en = 1'b0;
        wr(3'd2, 32'd4);
        wr(3'd0, 32'd1);
        wr(3'd3, 32'h00);
        n = 0;
        while ((tx !== 1'b0) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_tx_started", {31'd0, tx}, 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        reg_sel = 3'd1;
        #1;
        check("rst_mid_tx_line", {31'd0, tx}, 32'd1);
        check("rst_mid_stat", rdata, 32'h03);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(3'd2, d);
        check("rst_mid_baud", d, 32'd434);
        rd(3'd0, d);
        check("rst_mid_ctrl", d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
